// File: rtl/key_pkg.sv
// Shared types and helpers for the key front-end: step FSM states, key indices, counter sizing.
// Used by key_step_ctrl and debounce_cell.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    HELD   = 2'd2,
    REPEAT = 2'd3
  } step_state_t;

  localparam int KEY_ADDSUB = 0;
  localparam int KEY_SEL    = 1;
  localparam int KEY_CLR    = 2;
  localparam int KEY_STEP   = 3;

  // Width of a counter that must hold 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One raw active-low key: 2-flop synchroniser, stability counter, debounced level and
// a one-cycle strobe on each accepted press.
module debounce_cell
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic stable,
  output logic press
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // The flip happens on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= raw_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign press  = r_press;

endmodule

// File: rtl/key_step_ctrl.sv
// Key front-end for the add/sub accumulator: debounced step/clear strobes, coherent
// AddSub/Sel snapshots and a step counter. Optional auto-repeat via KEY_STEP_AUTO_REPEAT_EN.
module key_step_ctrl
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic       step,
  output logic       add_sub,
  output logic       sel,
  output logic       clr,
  output logic [7:0] step_cnt
);

  logic [3:0]  w_stable;
  logic [3:0]  w_press;
  step_state_t r_state;
  step_state_t w_state_next;
  logic        w_step_evt;
  logic        r_step;
  logic        r_clr;
  logic        r_add_sub;
  logic        r_sel;
  logic [7:0]  r_step_cnt;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
        .clk    (clk),
        .rst    (rst),
        .raw_n  (key_n[gi]),
        .stable (w_stable[gi]),
        .press  (w_press[gi])
      );
    end
  endgenerate

  // Level keys only matter as levels, Clear only as an edge.
  logic w_unused_keys;
  assign w_unused_keys = &{1'b0, w_press[KEY_SEL], w_press[KEY_ADDSUB], w_stable[KEY_CLR]};

`ifdef KEY_STEP_AUTO_REPEAT_EN
  localparam int            TMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            TW          = cnt_width(TMAX);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  always_comb begin
    w_state_next = r_state;
    w_step_evt   = 1'b0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
    w_timer_next = '0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_press[KEY_STEP]) begin
          w_state_next = FIRE;
          w_step_evt   = 1'b1;
        end
      end
      FIRE: w_state_next = HELD;
      HELD: begin
        if (w_stable[KEY_STEP]) begin
          w_state_next = IDLE;
`ifdef KEY_STEP_AUTO_REPEAT_EN
        end else if (r_timer == DELAY_LAST) begin
          w_state_next = REPEAT;
          w_step_evt   = 1'b1;
        end else begin
          w_timer_next = r_timer + 1'b1;
`endif
        end
      end
`ifdef KEY_STEP_AUTO_REPEAT_EN
      REPEAT: begin
        if (w_stable[KEY_STEP]) begin
          w_state_next = IDLE;
        end else if (r_timer == PERIOD_LAST) begin
          w_step_evt = 1'b1;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

`ifdef KEY_STEP_AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_timer <= '0;
    else     r_timer <= w_timer_next;
  end
`endif

  // A simultaneous Clear press wins: the step is swallowed but the FSM still consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_step     <= 1'b0;
      r_clr      <= 1'b0;
      r_add_sub  <= 1'b0;
      r_sel      <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_evt & ~w_press[KEY_CLR];
      r_clr   <= w_press[KEY_CLR];
      if (w_step_evt && !w_press[KEY_CLR]) begin
        r_add_sub <= ~w_stable[KEY_ADDSUB];
        r_sel     <= ~w_stable[KEY_SEL];
      end
      if (r_clr)       r_step_cnt <= '0;
      else if (r_step) r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

  assign step     = r_step;
  assign clr      = r_clr;
  assign add_sub  = r_add_sub;
  assign sel      = r_sel;
  assign step_cnt = r_step_cnt;

endmodule
